// File: rtl/i2c_slave_responder.sv
// I2C slave target: answers SLAVE_ADDR, passes bytes to/from a host over single-clock
// pulse handshakes, and reports a summary of every addressed transfer at STOP or repeated START.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | bus free, waiting for START
// S_ADDR     | shifting 7 address bits + R/W
// S_ADDR_ACK | driving the address ACK, then entering write or read
// S_WR_BYTE  | shifting in one data byte from the master
// S_WR_ACK   | driving the data ACK
// S_RD_BYTE  | shifting out one data byte to the master
// S_RD_ACK   | sampling the master ACK/NACK
// S_IGNORE   | not addressed or NACKed, SDA released until START/STOP
module i2c_slave_responder #(
   parameter int                        I2C_ADDR_WIDTH = 7,
   parameter int                        I2C_DATA_WIDTH = 8,
   parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDR     = 7'h22
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      scl_i,
   input  logic                      sda_i,
   output logic                      sda_o,
   output logic                      wr_valid,
   output logic [I2C_DATA_WIDTH-1:0] wr_data,
   output logic                      rd_req,
   input  logic [I2C_DATA_WIDTH-1:0] rd_data,
   output logic                      mon_valid,
   output logic [I2C_ADDR_WIDTH-1:0] mon_addr,
   output logic                      mon_op,
   output logic [7:0]                mon_len,
   output logic                      busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_IGNORE
   } state_t;

   state_t                    r_state;
   logic [1:0]                r_scl_sync;
   logic [1:0]                r_sda_sync;
   logic                      r_scl_d;
   logic                      r_sda_d;
   logic [7:0]                r_shift;
   logic [2:0]                r_cnt;
   logic                      r_phase;
   logic                      r_load;
   logic                      r_matched;
   logic                      r_rw;
   logic [I2C_ADDR_WIDTH-1:0] r_addr;
   logic [7:0]                r_len;

   logic       w_scl;
   logic       w_sda;
   logic       w_scl_rise;
   logic       w_scl_fall;
   logic       w_start;
   logic       w_stop;
   logic [7:0] w_shift_in;
   logic [7:0] w_len_inc;

   assign w_scl      = r_scl_sync[1];
   assign w_sda      = r_sda_sync[1];
   assign w_scl_rise = w_scl & ~r_scl_d;
   assign w_scl_fall = ~w_scl & r_scl_d;
   assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
   assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
   assign w_shift_in = {r_shift[6:0], w_sda};
   assign w_len_inc  = (r_len == 8'hFF) ? r_len : r_len + 8'd1;

   // Synchronisers idle high so reset release never looks like a START/STOP.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_scl_sync <= 2'b11;
         r_sda_sync <= 2'b11;
         r_scl_d    <= 1'b1;
         r_sda_d    <= 1'b1;
      end else begin
         r_scl_sync <= {r_scl_sync[0], scl_i};
         r_sda_sync <= {r_sda_sync[0], sda_i};
         r_scl_d    <= w_scl;
         r_sda_d    <= w_sda;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state   <= S_IDLE;
         r_shift   <= '0;
         r_cnt     <= '0;
         r_phase   <= 1'b0;
         r_load    <= 1'b0;
         r_matched <= 1'b0;
         r_rw      <= 1'b0;
         r_addr    <= '0;
         r_len     <= '0;
         sda_o     <= 1'b1;
         wr_valid  <= 1'b0;
         wr_data   <= '0;
         rd_req    <= 1'b0;
         mon_valid <= 1'b0;
         mon_addr  <= '0;
         mon_op    <= 1'b0;
         mon_len   <= '0;
         busy      <= 1'b0;
      end else begin
         wr_valid  <= 1'b0;
         rd_req    <= 1'b0;
         mon_valid <= 1'b0;
         r_load    <= 1'b0;
         // Host byte is taken one clock after rd_req; MSB goes straight onto the bus.
         if (r_load) begin
            r_shift <= rd_data;
            sda_o   <= rd_data[7];
         end
         if (w_start || w_stop) begin
            if (r_matched) begin
               mon_valid <= 1'b1;
               mon_addr  <= r_addr;
               mon_op    <= r_rw;
               mon_len   <= r_len;
            end
            r_matched <= 1'b0;
            busy      <= 1'b0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_phase   <= 1'b0;
            sda_o     <= 1'b1;
            r_state   <= w_start ? S_ADDR : S_IDLE;
         end else begin
            case (r_state)
               S_ADDR: if (w_scl_rise) begin
                  r_shift <= w_shift_in;
                  r_cnt   <= r_cnt + 3'd1;
                  if (r_cnt == 3'd7) begin
                     r_cnt <= '0;
                     if (w_shift_in[7:1] == SLAVE_ADDR) begin
                        r_addr  <= w_shift_in[7:1];
                        r_rw    <= w_shift_in[0];
                        busy    <= 1'b1;
                        r_phase <= 1'b0;
                        r_state <= S_ADDR_ACK;
                     end else begin
                        r_state <= S_IGNORE;
                     end
                  end
               end
               S_ADDR_ACK: if (w_scl_fall) begin
                  if (!r_phase) begin
                     sda_o     <= 1'b0;
                     r_phase   <= 1'b1;
                     r_matched <= 1'b1;
                  end else begin
                     r_phase <= 1'b0;
                     r_cnt   <= '0;
                     if (r_rw) begin
                        rd_req  <= 1'b1;
                        r_load  <= 1'b1;
                        r_state <= S_RD_BYTE;
                     end else begin
                        sda_o   <= 1'b1;
                        r_state <= S_WR_BYTE;
                     end
                  end
               end
               S_WR_BYTE: if (w_scl_rise) begin
                  r_shift <= w_shift_in;
                  r_cnt   <= r_cnt + 3'd1;
                  if (r_cnt == 3'd7) begin
                     wr_data  <= w_shift_in;
                     wr_valid <= 1'b1;
                     r_len    <= w_len_inc;
                     r_cnt    <= '0;
                     r_phase  <= 1'b0;
                     r_state  <= S_WR_ACK;
                  end
               end
               S_WR_ACK: if (w_scl_fall) begin
                  if (!r_phase) begin
                     sda_o   <= 1'b0;
                     r_phase <= 1'b1;
                  end else begin
                     sda_o   <= 1'b1;
                     r_phase <= 1'b0;
                     r_state <= S_WR_BYTE;
                  end
               end
               S_RD_BYTE: if (w_scl_fall) begin
                  if (r_cnt == 3'd7) begin
                     sda_o   <= 1'b1;
                     r_cnt   <= '0;
                     r_phase <= 1'b0;
                     r_state <= S_RD_ACK;
                  end else begin
                     sda_o   <= r_shift[6];
                     r_shift <= {r_shift[6:0], 1'b0};
                     r_cnt   <= r_cnt + 3'd1;
                  end
               end
               S_RD_ACK: begin
                  if (w_scl_rise) begin
                     r_len <= w_len_inc;
                     if (w_sda) r_state <= S_IGNORE;
                     else       r_phase <= 1'b1;
                  end else if (w_scl_fall && r_phase) begin
                     rd_req  <= 1'b1;
                     r_load  <= 1'b1;
                     r_phase <= 1'b0;
                     r_state <= S_RD_BYTE;
                  end
               end
               S_IDLE, S_IGNORE: ;
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: a bit-level I2C master plus a transaction-level
// expectation model (expected bytes, rd_req counts and monitor records).
module tb_i2c_slave_responder;

   localparam logic [6:0] SLV = 7'h22;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       m_scl;
   logic       m_sda;
   logic       sda_o;
   logic       wr_valid;
   logic [7:0] wr_data;
   logic       rd_req;
   logic [7:0] rd_data = 8'h00;
   logic       mon_valid;
   logic [6:0] mon_addr;
   logic       mon_op;
   logic [7:0] mon_len;
   logic       busy;
   logic       w_bus;

   assign w_bus = m_sda & sda_o;

   i2c_slave_responder dut (
      .clk_i(clk_i), .rst_i(rst_i), .scl_i(m_scl), .sda_i(w_bus), .sda_o(sda_o),
      .wr_valid(wr_valid), .wr_data(wr_data), .rd_req(rd_req), .rd_data(rd_data),
      .mon_valid(mon_valid), .mon_addr(mon_addr), .mon_op(mon_op), .mon_len(mon_len),
      .busy(busy)
   );

   always #5 clk_i = ~clk_i;

   int total = 0;
   int bad = 0;

   logic [7:0]  got_wr[$];
   logic [15:0] got_mon[$];
   logic [7:0]  rd_q[$];
   int          got_rdreq = 0;
   int          overlap = 0;
   int          sda_low_cnt = 0;

   logic [7:0]  exp_wr[$];
   logic [15:0] exp_mon[$];
   int          exp_rdreq = 0;
   int          p_wr = 0;
   int          p_mon = 0;
   logic [7:0]  dbuf[8];

   // Host side: capture pulses and hand over the next read byte after each rd_req.
   always @(negedge clk_i) begin
      if (rst_i) begin
         if (wr_valid) got_wr.push_back(wr_data);
         if (mon_valid) got_mon.push_back({mon_addr, mon_op, mon_len});
         if (wr_valid && rd_req) overlap++;
         if (rd_req) begin
            got_rdreq++;
            if (rd_q.size() > 0) rd_data = rd_q.pop_front();
         end
      end
      if (sda_o === 1'b0) sda_low_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wt(input int n);
      repeat (n) @(posedge clk_i);
      #2;
   endtask

   task automatic bit_x(input bit b, output bit v);
      wt(10); m_sda = b;
      wt(10); m_scl = 1'b1;
      wt(10); v = w_bus;
      wt(10); m_scl = 1'b0;
   endtask

   task automatic start();
      wt(10); m_sda = 1'b0;
      wt(10); m_scl = 1'b0;
   endtask

   task automatic sr();
      wt(10); m_sda = 1'b1;
      wt(10); m_scl = 1'b1;
      wt(10); m_sda = 1'b0;
      wt(10); m_scl = 1'b0;
   endtask

   task automatic stop();
      wt(10); m_sda = 1'b0;
      wt(10); m_scl = 1'b1;
      wt(10); m_sda = 1'b1;
      wt(10);
   endtask

   task automatic send_byte(input logic [7:0] b, output bit ack);
      bit v;
      for (int i = 7; i >= 0; i--) bit_x(b[i], v);
      bit_x(1'b1, ack);
   endtask

   task automatic recv_byte(output logic [7:0] b, input bit nack);
      bit v;
      for (int i = 7; i >= 0; i--) begin
         bit_x(1'b1, v);
         b[i] = v;
      end
      bit_x(nack, v);
   endtask

   task automatic xfer(input logic [6:0] addr, input bit rd, input int n, input bit rep, input bit fin);
      bit ack;
      bit m;
      int low0;
      logic [7:0] got;
      m = (addr == SLV);
      if (m && rd) for (int i = 0; i < n; i++) rd_q.push_back(dbuf[i]);
      low0 = sda_low_cnt;
      if (rep) sr(); else start();
      send_byte({addr, rd}, ack);
      chk("addr_ack", 32'(ack), m ? 32'd0 : 32'd1);
      if (m) begin
         chk("busy_in_xfer", 32'(busy), 32'd1);
         for (int i = 0; i < n; i++) begin
            if (!rd) begin
               send_byte(dbuf[i], ack);
               exp_wr.push_back(dbuf[i]);
               chk("data_ack", 32'(ack), 32'd0);
            end else begin
               recv_byte(got, i == n - 1);
               chk("rd_byte", 32'(got), 32'(dbuf[i]));
            end
         end
         if (rd) exp_rdreq += n;
         exp_mon.push_back({addr, rd, 8'(n)});
      end else begin
         chk("unmatched_sda_released", 32'(sda_low_cnt - low0), 32'd0);
      end
      if (fin) stop();
   endtask

   task automatic check_all();
      wt(10);
      chk("wr_count", 32'(got_wr.size()), 32'(exp_wr.size()));
      for (int i = p_wr; i < exp_wr.size() && i < got_wr.size(); i++)
         chk("wr_data", 32'(got_wr[i]), 32'(exp_wr[i]));
      chk("mon_count", 32'(got_mon.size()), 32'(exp_mon.size()));
      for (int i = p_mon; i < exp_mon.size() && i < got_mon.size(); i++)
         chk("mon_rec", 32'(got_mon[i]), 32'(exp_mon[i]));
      chk("rd_req_count", 32'(got_rdreq), 32'(exp_rdreq));
      chk("busy_after", 32'(busy), 32'd0);
      chk("sda_idle", 32'(sda_o), 32'd1);
      p_wr  = exp_wr.size();
      p_mon = exp_mon.size();
   endtask

   initial begin
      logic [7:0] ab;
      logic [6:0] ra;
      bit v, rd;
      int n;
      m_scl = 1'b1;
      m_sda = 1'b1;
      rst_i = 1'b0;
      wt(5);
      chk("rst_sda_o", 32'(sda_o), 32'd1);
      chk("rst_wr_valid", 32'(wr_valid), 32'd0);
      chk("rst_rd_req", 32'(rd_req), 32'd0);
      chk("rst_mon_valid", 32'(mon_valid), 32'd0);
      chk("rst_wr_data", 32'(wr_data), 32'd0);
      chk("rst_mon", 32'({mon_addr, mon_op, mon_len}), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst_i = 1'b1;
      wt(5);

      dbuf[0] = 8'hA5;
      xfer(SLV, 1'b0, 1, 1'b0, 1'b1);
      check_all();

      dbuf[0] = 8'h3C; dbuf[1] = 8'hC3;
      xfer(SLV, 1'b1, 2, 1'b0, 1'b1);
      check_all();

      dbuf[0] = 8'h77;
      xfer(7'h23, 1'b0, 1, 1'b0, 1'b1);
      check_all();

      dbuf[0] = 8'h11;
      xfer(SLV, 1'b0, 1, 1'b0, 1'b0);
      dbuf[0] = 8'h9E;
      xfer(SLV, 1'b1, 1, 1'b1, 1'b1);
      check_all();

      dbuf[0] = 8'h01; dbuf[1] = 8'h02; dbuf[2] = 8'h03;
      xfer(SLV, 1'b0, 3, 1'b0, 1'b1);
      check_all();

      // Partial byte before STOP must be dropped and not counted.
      dbuf[0] = 8'h6B;
      xfer(SLV, 1'b0, 1, 1'b0, 1'b0);
      bit_x(1'b1, v); bit_x(1'b0, v); bit_x(1'b1, v);
      stop();
      check_all();

      // Reset while the slave is pulling SDA low for the address ACK.
      ab = {SLV, 1'b0};
      start();
      for (int i = 7; i >= 0; i--) bit_x(ab[i], v);
      wt(10);
      chk("ack_driven_pre_rst", 32'(sda_o), 32'd0);
      rst_i = 1'b0;
      #1;
      chk("rst_mid_sda", 32'(sda_o), 32'd1);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      wt(3);
      rst_i = 1'b1;
      wt(3);
      m_sda = 1'b1;
      m_scl = 1'b1;
      wt(10);
      dbuf[0] = 8'h5A;
      xfer(SLV, 1'b0, 1, 1'b0, 1'b1);
      check_all();

      for (int k = 0; k < 8; k++) begin
         rd = 1'($urandom_range(0, 1));
         n  = int'($urandom_range(1, 4));
         if ($urandom_range(0, 3) != 0) ra = SLV;
         else begin
            ra = 7'($urandom_range(0, 127));
            if (ra == SLV) ra = ra ^ 7'h01;
         end
         for (int i = 0; i < 8; i++) dbuf[i] = 8'($urandom);
         xfer(ra, rd, n, 1'b0, 1'b1);
         check_all();
      end

      chk("no_overlap", 32'(overlap), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
